// File: rtl/prod_bcd_conv.sv
// -----------------------------------------------------------------------------
// prod_bcd_conv
//   Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) that
//   sits after the 3x3 unsigned array multiplier. It captures the product on a
//   start strobe and converts one bit per clock. The packed BCD digits are
//   handed to the display stage through a busy/done handshake.
//
// Parameters
//   IN_W    binary input width (multiplier product width)
//   DIGITS  number of BCD output digits; 10**DIGITS must exceed 2**IN_W-1
//
// Ports
//   clk      in   1         rising-edge clock
//   rst      in   1         synchronous, active-high reset (overrides start)
//   start    in   1         conversion request, accepted in IDLE or DONE
//   prod_in  in   IN_W      unsigned binary value, captured when start is accepted
//   bcd_out  out  4*DIGITS  packed BCD, [3:0]=ones, [7:4]=tens, ...; registered
//   busy     out  1         high while the shift sequence runs
//   done     out  1         one-cycle pulse; bcd_out has just been updated
// -----------------------------------------------------------------------------
module prod_bcd_conv #(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       prod_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  // Too few digits would let a scratch digit overflow past 9.
  if ((10 ** DIGITS) <= ((2 ** IN_W) - 1)) begin : g_digits_too_small
    $error("prod_bcd_conv: DIGITS=%0d cannot hold 2**IN_W-1 for IN_W=%0d", DIGITS, IN_W);
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    sh_q, sh_d;       // {scratch digits, remaining binary bits}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SH_W-1:0]    shifted;

  // Add 3 to every digit that is 5 or more, so that the following left shift
  // carries into the next digit exactly when the doubled value reaches 10.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    shifted = {add3(sh_q[SH_W-1:IN_W]), sh_q[IN_W-1:0]} << 1;

    case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back runs.
      S_IDLE, S_DONE: begin
        if (start) begin
          sh_d    = {{BCD_W{1'b0}}, prod_in};
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sh_d  = shifted;
        cnt_d = cnt_q + CNT_W'(1);
        // This edge performs the last shift: publish the digits it produces.
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          bcd_d   = shifted[SH_W-1:IN_W];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags come from the next state so they leave a flop cleanly.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bcd_out = bcd_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_prod_bcd_conv
//   Self-checking bench for prod_bcd_conv. Expected BCD values come from a
//   decimal-division model; timing expectations come from the handshake rules.
// -----------------------------------------------------------------------------
module tb_prod_bcd_conv;

  localparam int IN_W   = 6;
  localparam int DIGITS = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [IN_W-1:0]      prod_in;
  logic [4*DIGITS-1:0]  bcd_out;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [4*DIGITS-1:0] last_bcd;
  int last_done_cyc;

  prod_bcd_conv #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .prod_in (prod_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: peel decimal digits off with / and %.
  function automatic logic [4*DIGITS-1:0] bcd_ref(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion of v (caller guarantees IDLE or DONE state) and follow
  // it to the done pulse. mode 0: quiet; 1: start with prod_in=35 at busy
  // cycles 2 and 4; 2: random start pokes while busy.
  task automatic convert(input logic [IN_W-1:0] v, input int mode, input string tag);
    int  lat;
    int  busy_cnt;
    bit  seen;
    start   = 1'b1;
    prod_in = v;
    tick();
    start    = 1'b0;
    prod_in  = IN_W'($urandom);
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && lat < 20) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        chk({tag, "_hold"}, bcd_out, last_bcd);
        case (mode)
          1: begin
            start   = (lat == 2 || lat == 4);
            prod_in = 6'd35;
          end
          2: begin
            start   = ($urandom_range(0, 1) == 1) && (lat < IN_W - 1);
            prod_in = IN_W'($urandom);
          end
          default: start = 1'b0;
        endcase
        tick();
        start = 1'b0;
        lat++;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, lat, IN_W);
    chk({tag, "_busycnt"}, busy_cnt, IN_W);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_bcd"}, bcd_out, bcd_ref(int'(v)));
    last_bcd      = bcd_ref(int'(v));
    last_done_cyc = cyc;
  endtask

  // One idle cycle after a done pulse: done must drop, busy stays low.
  task automatic after_done(input string tag);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_bcd"}, bcd_out, last_bcd);
  endtask

  initial begin
    int first_done;
    int dones;
    int gap;
    logic [IN_W-1:0] v;

    rst      = 1'b1;
    start    = 1'b0;
    prod_in  = '0;
    last_bcd = '0;
    tick();
    // Reset must dominate start.
    start   = 1'b1;
    prod_in = 6'd17;
    tick();
    chk("rst_over_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    tick();
    chk("reset_bcd", bcd_out, 8'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Zero, multiplier maximum, and full-range maximum.
    convert(6'd0, 0, "zero");
    after_done("zero");
    convert(6'd49, 0, "max49");
    after_done("max49");
    convert(6'd63, 0, "max63");
    after_done("max63");

    // Every 3x3 operand pair through the multiplier product.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        convert(IN_W'(a * b), 0, "sweep");
      end
    end
    after_done("sweep");

    // Start pokes during SHIFT are ignored; exactly one done pulse.
    convert(6'd10, 1, "ignore");
    after_done("ignore");
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
    end
    chk("ignore_extra_done", dones, 0);

    // Back-to-back: start in the DONE cycle, no idle cycle between runs.
    convert(6'd5, 0, "b2b_first");
    first_done = last_done_cyc;
    convert(6'd21, 0, "b2b_second");
    chk("b2b_spacing", last_done_cyc - first_done, IN_W + 1);
    after_done("b2b");

    // Reset in the middle of a conversion aborts it.
    start   = 1'b1;
    prod_in = 6'd42;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_bcd", bcd_out, 8'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    last_bcd = '0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("abort_no_done", dones, 0);
    convert(6'd42, 0, "after_abort");
    after_done("after_abort");

    // Random values, random gaps (0 = back-to-back), random start pokes.
    for (int n = 0; n < 40; n++) begin
      v = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      convert(v, 2, "rand");
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        after_done("rand");
        for (int g = 1; g < gap; g++) tick();
      end
    end
    after_done("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
